// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Round-robin arbiter for one shared memory bus lane (e.g. va_pa or
// addr_data). Requesters (ITLB, ICache, DTLB, DCache by default) raise
// in_reqcyc, wait for a registered one-hot grant, then hold in_busy for their
// whole tenure. The grant is held until the owner releases the lane. A
// watchdog revokes a grant whose owner never starts using the lane.
//
// Ports
//   clk          clock, all state on posedge
//   reset        asynchronous, active-high; clears all state
//   in_reqcyc    per-requester request, level, held until granted
//   in_busy      per-requester "using lane"; only the owner's bit matters
//   out_grant    registered one-hot grant, all-zero when idle
//   out_owner    index of current/last owner (meaningful when out_valid=1)
//   out_valid    high while some grant is asserted
//   out_timeout  one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] in_reqcyc,
  input  logic [NUM_REQ-1:0] in_busy,
  output logic [NUM_REQ-1:0] out_grant,
  output logic [IDX_W-1:0]   out_owner,
  output logic               out_valid,
  output logic               out_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] RESET_OWNER  = IDX_W'(NUM_REQ - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             seen_busy;

  logic [IDX_W-1:0] winner;
  logic             owner_busy;
  logic             owner_req;

  // Circular search starting just after the last owner, so the last owner
  // has lowest priority. Walking the offsets from farthest to nearest lets
  // the nearest set request overwrite the others without a "found" flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    winner = out_owner;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (in_reqcyc[(int'(out_owner) + i) % NUM_REQ]) begin
        winner = IDX_W'((int'(out_owner) + i) % NUM_REQ);
      end
    end
  end

  assign owner_busy = in_busy[out_owner];
  assign owner_req  = in_reqcyc[out_owner];

  // Single registered FSM; all outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_grant   <= '0;
      out_owner   <= RESET_OWNER;
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;
      counter     <= '0;
      seen_busy   <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every branch sees
      // the pre-edge values; out_timeout defaults low so it can only pulse.
      out_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|in_reqcyc) begin
            out_grant <= NUM_REQ'(1) << winner;
            out_owner <= winner;
            out_valid <= 1'b1;
            counter   <= '0;
            seen_busy <= 1'b0;
            state     <= GRANT;
          end
        end

        GRANT: begin
          // Branch order encodes priority: tenure done > withdraw > timeout.
          if (seen_busy && !owner_busy) begin
            out_grant <= '0;
            out_valid <= 1'b0;
            state     <= TURN;
          end else if (owner_busy) begin
            seen_busy <= 1'b1;
          end else if (!owner_req) begin
            out_grant <= '0;
            out_valid <= 1'b0;
            state     <= TURN;
          end else if (counter == TIMEOUT_LAST) begin
            out_grant   <= '0;
            out_valid   <= 1'b0;
            out_timeout <= 1'b1;
            state       <= TURN;
          end else if (counter != '1) begin
            // Watchdog only runs before the owner first goes busy.
            counter <= counter + 1'b1;
          end
        end

        // One dead cycle of bus turnaround before the next arbitration.
        TURN: begin
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          out_grant <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter with the default parameters (4
// requesters, 16-cycle watchdog). Inputs change 1 time unit after a rising
// edge and outputs are compared at the same point, so each tick() advances
// exactly one registered cycle.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] in_reqcyc;
  logic [3:0] in_busy;
  logic [3:0] out_grant;
  logic [1:0] out_owner;
  logic       out_valid;
  logic       out_timeout;

  int vectors     = 0;
  int miscompares = 0;

  mem_bus_arbiter #(
    .NUM_REQ     (4),
    .IDX_W       (2),
    .BUSY_TIMEOUT(16),
    .CNT_W       (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_reqcyc  (in_reqcyc),
    .in_busy    (in_busy),
    .out_grant  (out_grant),
    .out_owner  (out_owner),
    .out_valid  (out_valid),
    .out_timeout(out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant must be one-hot or zero in every cycle.
  always @(negedge clk) begin
    vectors++;
    if (!$onehot0(out_grant)) begin
      miscompares++;
      $display("FAIL onehot t=%0t got %b required at most one bit", $time, out_grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_reqcyc = 4'b0000;
    in_busy   = 4'b0000;
    #2;
    vectors++;
    if (out_grant !== 4'b0000 || out_valid !== 1'b0 || out_timeout !== 1'b0 || out_owner !== 2'd3) begin
      miscompares++;
      $display("FAIL reset_state got grant=%b valid=%b to=%b owner=%0d required 0000/0/0/3",
               out_grant, out_valid, out_timeout, out_owner);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (out_grant !== 4'b0000 || out_valid !== 1'b0 || out_owner !== 2'd3) begin
      miscompares++;
      $display("FAIL idle_no_req got grant=%b valid=%b owner=%0d required 0000/0/3",
               out_grant, out_valid, out_owner);
    end
  endtask

  // All four requesting; each owner busy 3 cycles. Order 0,1,2,3,0 with a
  // TURN cycle and an IDLE cycle between tenures.
  task automatic test_rotation();
    logic [1:0] e;
    logic [3:0] exp_g;
    in_reqcyc = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e     = 2'(k % 4);
      exp_g = 4'b0001 << e;
      tick();
      vectors++;
      if (out_grant !== exp_g || out_owner !== e || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rot_grant k=%0d got grant=%b owner=%0d valid=%b required %b/%0d/1",
                 k, out_grant, out_owner, out_valid, exp_g, e);
      end
      if (k == 4) in_reqcyc = 4'b0000;
      in_busy = exp_g;
      for (int c = 0; c < 3; c++) begin
        tick();
        vectors++;
        if (out_grant !== exp_g) begin
          miscompares++;
          $display("FAIL rot_hold k=%0d c=%0d got %b required %b", k, c, out_grant, exp_g);
        end
      end
      in_busy = 4'b0000;
      tick();
      vectors++;
      if (out_grant !== 4'b0000 || out_valid !== 1'b0 || out_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL rot_turn k=%0d got grant=%b valid=%b to=%b required 0000/0/0",
                 k, out_grant, out_valid, out_timeout);
      end
      tick();
      vectors++;
      if (out_grant !== 4'b0000 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rot_idle k=%0d got grant=%b valid=%b required 0000/0", k, out_grant, out_valid);
      end
    end
  endtask

  // Owner 1 never goes busy: revocation exactly 16 cycles after the grant.
  task automatic test_timeout();
    in_reqcyc = 4'b0010;
    tick();
    vectors++;
    if (out_grant !== 4'b0010 || out_owner !== 2'd1) begin
      miscompares++;
      $display("FAIL to_grant got grant=%b owner=%0d required 0010/1", out_grant, out_owner);
    end
    for (int c = 1; c <= 15; c++) begin
      tick();
      vectors++;
      if (out_grant !== 4'b0010 || out_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL to_hold c=%0d got grant=%b to=%b required 0010/0", c, out_grant, out_timeout);
      end
    end
    tick();
    vectors++;
    if (out_timeout !== 1'b1 || out_grant !== 4'b0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL to_pulse got to=%b grant=%b valid=%b required 1/0000/0",
               out_timeout, out_grant, out_valid);
    end
    tick();
    vectors++;
    if (out_timeout !== 1'b0 || out_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL to_after got to=%b grant=%b required 0/0000", out_timeout, out_grant);
    end
    tick();
    vectors++;
    if (out_grant !== 4'b0010 || out_owner !== 2'd1) begin
      miscompares++;
      $display("FAIL to_regrant got grant=%b owner=%0d required 0010/1", out_grant, out_owner);
    end
    in_reqcyc = 4'b0000;
    tick();
    tick();
  endtask

  // Owner 3 withdraws before busy; requester 0 pending is granted after
  // TURN and IDLE, with no timeout pulse.
  task automatic test_withdraw();
    in_reqcyc = 4'b1001;
    tick();
    vectors++;
    if (out_grant !== 4'b1000 || out_owner !== 2'd3) begin
      miscompares++;
      $display("FAIL wd_grant got grant=%b owner=%0d required 1000/3", out_grant, out_owner);
    end
    in_reqcyc = 4'b0001;
    tick();
    vectors++;
    if (out_grant !== 4'b0000 || out_timeout !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_turn got grant=%b to=%b valid=%b required 0000/0/0",
               out_grant, out_timeout, out_valid);
    end
    tick();
    vectors++;
    if (out_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL wd_idle got %b required 0000", out_grant);
    end
    tick();
    vectors++;
    if (out_grant !== 4'b0001 || out_owner !== 2'd0) begin
      miscompares++;
      $display("FAIL wd_next got grant=%b owner=%0d required 0001/0", out_grant, out_owner);
    end
    in_reqcyc = 4'b0000;
    tick();
    tick();
  endtask

  // Non-owners toggle busy during owner 2's tenure; nothing may change.
  task automatic test_nonowner_busy();
    in_reqcyc = 4'b0100;
    tick();
    vectors++;
    if (out_grant !== 4'b0100 || out_owner !== 2'd2) begin
      miscompares++;
      $display("FAIL nb_grant got grant=%b owner=%0d required 0100/2", out_grant, out_owner);
    end
    for (int i = 0; i < 6; i++) begin
      in_busy = (i % 2 == 0) ? 4'b1011 : 4'b0000;
      tick();
      vectors++;
      if (out_grant !== 4'b0100 || out_valid !== 1'b1 || out_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL nb_hold i=%0d got grant=%b valid=%b to=%b required 0100/1/0",
                 i, out_grant, out_valid, out_timeout);
      end
    end
    in_busy = 4'b0100;
    tick();
    tick();
    vectors++;
    if (out_grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL nb_busy got %b required 0100", out_grant);
    end
    in_reqcyc = 4'b0000;
    in_busy   = 4'b1011;
    tick();
    vectors++;
    if (out_grant !== 4'b0000 || out_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL nb_done got grant=%b to=%b required 0000/0", out_grant, out_timeout);
    end
    in_busy = 4'b0000;
    tick();
  endtask

  // Reset during a busy tenure drops the grant without a clock edge;
  // arbitration then restarts from requester 0.
  task automatic test_reset_mid();
    in_reqcyc = 4'b1111;
    tick();
    vectors++;
    if (out_grant !== 4'b1000 || out_owner !== 2'd3) begin
      miscompares++;
      $display("FAIL rm_grant got grant=%b owner=%0d required 1000/3", out_grant, out_owner);
    end
    in_busy = 4'b1000;
    tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_grant !== 4'b0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_async got grant=%b valid=%b required 0000/0", out_grant, out_valid);
    end
    tick();
    tick();
    reset   = 1'b0;
    in_busy = 4'b0000;
    tick();
    vectors++;
    if (out_grant !== 4'b0001 || out_owner !== 2'd0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_restart got grant=%b owner=%0d valid=%b required 0001/0/1",
               out_grant, out_owner, out_valid);
    end
    in_reqcyc = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_withdraw();
    test_nonowner_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
